// File: rtl/conv_out_sched.sv
// Output scheduler: re-times masked kernel windows through a 2-entry
// skid buffer onto an AXI-Stream master with tuser/tlast framing.
module conv_out_sched #(
  parameter int IMG_W  = 1920,
  parameter int IMG_H  = 1080,
  parameter int DATA_W = 200
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              win_vld_i,
  input  logic [DATA_W-1:0] win_dat_i,
  output logic              win_rdy_o,
  input  logic              flush_i,
  input  logic              m_tready_i,
  output logic              m_tvalid_o,
  output logic [DATA_W-1:0] m_tdata_o,
  output logic              m_tuser_o,
  output logic              m_tlast_o,
  output logic              frame_done_o,
  output logic              busy_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int EW = DATA_W + 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACT   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [EW-1:0] mem_q [2];
  logic          head_q, head_d;
  logic          tail_q, tail_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [1:0]    state_q, state_d;
  logic          rdy_q, rdy_d;

  logic          acc, xfer, eof_xfer;
  logic          col_last, row_last;
  logic [EW-1:0] head_e, wr_e;

  always_comb begin
    acc      = win_vld_i & rdy_q & ~flush_i;
    xfer     = (cnt_q != 2'd0) & m_tready_i;
    head_e   = mem_q[head_q];
    eof_xfer = xfer & head_e[EW-1];
    col_last = (col_q == CW'(IMG_W - 1));
    row_last = (row_q == RW'(IMG_H - 1));
    // {eof, tlast, tuser, data} captured at accept time
    wr_e = {col_last & row_last, col_last,
            (row_q == '0) & (col_q == '0), win_dat_i};

    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;

    if (flush_i) begin
      head_d  = 1'b0;
      tail_d  = 1'b0;
      cnt_d   = 2'd0;
      col_d   = '0;
      row_d   = '0;
      state_d = S_IDLE;
    end else begin
      if (acc) begin
        tail_d = ~tail_q;
        if (col_last) begin
          col_d = '0;
          row_d = row_last ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      if (xfer) head_d = ~head_q;
      case ({acc, xfer})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
      case (state_q)
        S_IDLE:  if (acc) state_d = S_ACT;
        S_ACT:   if (acc && col_last && row_last) state_d = S_DRAIN;
        S_DRAIN: if (eof_xfer) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // next frame is held off until the current one has fully left
    rdy_d = (cnt_d != 2'd2) && (state_d != S_DRAIN);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      cnt_q    <= 2'd0;
      col_q    <= '0;
      row_q    <= '0;
      state_q  <= S_IDLE;
      rdy_q    <= 1'b1;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      state_q <= state_d;
      rdy_q   <= rdy_d;
      if (acc) mem_q[tail_q] <= wr_e;
    end
  end

  assign win_rdy_o    = rdy_q;
  assign m_tvalid_o   = (cnt_q != 2'd0);
  assign m_tdata_o    = head_e[DATA_W-1:0];
  assign m_tuser_o    = head_e[DATA_W];
  assign m_tlast_o    = head_e[DATA_W+1];
  assign frame_done_o = eof_xfer & ~flush_i;
  assign busy_o       = (state_q != S_IDLE) || (cnt_q != 2'd0);

endmodule

// File: doc/conv_out_sched.md
Name: conv_out_sched

Overview:
- Output-side scheduler for the convolution datapath: accepts masked kernel windows (one per output pixel) and re-times them through a 2-entry skid buffer onto an AXI-Stream master port.
- Generates the stream framing: tuser on the first window of a frame, tlast on the last window of each row.
- Tracks row/column position, asserts a frame-done pulse, and exerts back-pressure upstream (kernel pipeline) so no window is dropped when m_tready_i deasserts.

Parameters:
- IMG_W, 1920, image width in pixels (windows per row); >=2.
- IMG_H, 1080, image height in rows (rows per frame); >=2.
- DATA_W, 200, kernel window width in bits (5x5 x 8-bit pixels).

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- win_vld_i  in  1  kernel window valid.
- win_dat_i  in  DATA_W  masked kernel window.
- win_rdy_o  out  1  window accepted when win_vld_i & win_rdy_o.
- flush_i  in  1  synchronous abort: discard buffer, reset position.
- m_tready_i  in  1  downstream ready.
- m_tvalid_o  out  1  output valid.
- m_tdata_o  out  DATA_W  output window.
- m_tuser_o  out  1  start of frame (row 0, col 0).
- m_tlast_o  out  1  end of row (col IMG_W-1).
- frame_done_o  out  1  one-cycle pulse when the last window of a frame transfers on m_*.
- busy_o  out  1  frame in progress (ACTIVE state or buffer non-empty).

Behaviour:
- Reset (arst_n=0, asynchronous): m_tvalid_o=0, win_rdy_o=1, frame_done_o=0, busy_o=0; col=row=0; buffer empty; FSM=IDLE. m_tdata_o/m_tuser_o/m_tlast_o are don't-care while m_tvalid_o=0.
- Counters: col width $clog2(IMG_W), row width $clog2(IMG_H). Advance on input accept: col++; at col==IMG_W-1, col->0 and row++; at row==IMG_H-1 and col==IMG_W-1, both -> 0.
- Framing bits are computed at accept time and stored with the data: tuser=(row==0 && col==0); tlast=(col==IMG_W-1); eof=(tlast && row==IMG_H-1). eof is internal only.
- Buffer: 2 entries, head/tail pointers plus count 0..2.
  - win_rdy_o is registered, = (count_next < 2).
  - Output is driven from the head entry. m_tvalid_o = (count != 0), registered.
  - Latency: a window accepted in cycle N is presented on m_* in cycle N+1 if the buffer was empty.
- Handshake:
  - Once asserted, m_tvalid_o and m_* data stay stable until m_tready_i=1.
  - Simultaneous accept and transfer with count=2 is impossible, since win_rdy_o=0.
  - Simultaneous accept and transfer with count=1 leaves count unchanged.
  - Full throughput: 1 window/cycle while m_tready_i=1.
- FSM:
  - IDLE -> ACTIVE on the first accept.
  - ACTIVE -> DRAIN on accepting the eof window.
  - DRAIN -> IDLE when the eof entry transfers. frame_done_o pulses that cycle.
  - In DRAIN, win_rdy_o=0: the next frame is not accepted until the previous one has fully left.
- flush_i: highest priority, takes effect next cycle. Clears count, pointers, col and row; FSM->IDLE; m_tvalid_o=0; no frame_done pulse. A window presented in the flush cycle is dropped.
- Reset mid-frame: identical to flush, but asynchronous.
- Assertions (tb only):
  - m_tvalid_o must not drop without m_tready_i.
  - count never exceeds 2.

Test Plan:
- IMG_W=4, IMG_H=3, m_tready_i=1, 12 back-to-back windows with data=index 0..11:
  - 12 consecutive output beats.
  - tuser only on beat 0; tlast on beats 3, 7, 11.
  - frame_done_o pulses in the beat-11 transfer cycle; busy_o=0 the next cycle.
- Back-pressure: m_tready_i=0 for cycles 2-6 during a stream:
  - win_rdy_o drops after 2 windows are buffered.
  - m_tdata_o holds value 1 stable throughout.
  - Order 0..11 is preserved and no window is lost or duplicated.
- Frame boundary: present window 0 of frame 2 immediately after window 11:
  - not accepted until the eof transfer.
  - window 0 of frame 2 then carries tuser=1.
- Random m_tready_i (50%) across 3 frames:
  - output sequence matches the scoreboard.
  - tlast count equals 9; frame_done count equals 3.
- flush_i after window 5, with the buffer holding 2 windows:
  - next cycle m_tvalid_o=0.
  - a new stream restarts with tuser=1 at data 0.
  - no frame_done pulse.
- arst_n low mid-frame with m_tvalid_o=1:
  - outputs go to reset values immediately.
  - after release, a fresh 12-window frame is framed correctly.
